// File: rtl/hazard_control_unit_v2.sv
// Pipeline hazard and exception sequencer: per-stage stall/flush, PC-source select,
// exception vectoring, post-exception flush drain and a memory-stall watchdog.
module hazard_control_unit_v2 #(
   parameter int unsigned      XLEN          = 32,
   parameter int unsigned      RA_W          = 5,
   parameter logic [XLEN-1:0]  EXC_BASE      = 'h10,
   parameter int unsigned      VECTORED      = 0,
   parameter logic [XLEN-1:0]  VEC_STRIDE    = 'h20,
   parameter int unsigned      DRAIN_CYCLES  = 2,
   parameter int unsigned      STALL_TIMEOUT = 64,
   parameter int unsigned      LU_R0_EXEMPT  = 1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_id_jmp,
   input  logic            i_mem_jr,
   input  logic            i_mem_branch_state,
   input  logic            i_mem_stall,
   input  logic [XLEN-1:0] i_mem_excepttype,
   input  logic            i_idex_mem_r,
   input  logic [RA_W-1:0] i_ifid_rs_addr,
   input  logic [RA_W-1:0] i_ifid_real_rt_addr,
   input  logic [RA_W-1:0] i_idex_real_rd_addr,
   output logic [4:0]      o_cu_stall,
   output logic [2:0]      o_cu_flush,
   output logic [2:0]      o_cu_pc_src,
   output logic [XLEN-1:0] o_cu_vector,
   output logic [4:0]      o_cu_cause,
   output logic            o_cu_exc_busy
);

   localparam int unsigned DrainW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
   localparam int unsigned StallW = $clog2(STALL_TIMEOUT);
   localparam logic [StallW-1:0] StallMax  = StallW'(STALL_TIMEOUT - 1);
   localparam logic [DrainW-1:0] DrainInit = DrainW'(DRAIN_CYCLES - 1);
   localparam logic [XLEN-1:0] CodeEret    = 'hD;
   localparam logic [XLEN-1:0] CodeTimeout = 'hE;

   localparam logic [2:0] PcJmp    = 3'd0;
   localparam logic [2:0] PcExcept = 3'd1;
   localparam logic [2:0] PcEret   = 3'd2;
   localparam logic [2:0] PcCtrl   = 3'd3;
   localparam logic [2:0] PcSeq    = 3'd4;

   typedef enum logic [0:0] {StRun, StDrain} state_e;

   state_e            r_state, w_state_nxt;
   logic [DrainW-1:0] r_drain_cnt, w_drain_nxt;
   logic [StallW-1:0] r_stall_cnt, w_stall_nxt;
   logic [4:0]        r_cause, w_cause_nxt;

   logic            w_timeout;
   logic            w_load_use;
   logic            w_exc_take;
   logic [XLEN-1:0] w_code;
   logic [XLEN-1:0] w_exc_vec;

   assign w_timeout = i_mem_stall && (r_stall_cnt == StallMax);
   assign w_code    = w_timeout ? CodeTimeout : i_mem_excepttype;
   assign w_exc_vec = ((VECTORED != 0) && (w_code >= XLEN'(1)) && (w_code <= XLEN'(8)))
                      ? EXC_BASE + w_code * VEC_STRIDE : EXC_BASE;

   assign w_load_use = i_idex_mem_r
                       && ((i_ifid_rs_addr == i_idex_real_rd_addr)
                           || (i_ifid_real_rt_addr == i_idex_real_rd_addr))
                       && !((LU_R0_EXEMPT != 0) && (i_idex_real_rd_addr == '0));

   assign o_cu_cause = r_cause;

   always_comb begin
      o_cu_stall    = '0;
      o_cu_flush    = '0;
      o_cu_pc_src   = PcSeq;
      o_cu_vector   = '0;
      o_cu_exc_busy = 1'b0;
      w_state_nxt   = r_state;
      w_drain_nxt   = r_drain_cnt;
      w_cause_nxt   = r_cause;
      w_exc_take    = 1'b0;
      // Watchdog counts consecutive stall cycles in either state, saturating.
      w_stall_nxt   = i_mem_stall ? ((r_stall_cnt == StallMax) ? r_stall_cnt : r_stall_cnt + 1'b1)
                                  : '0;

      if (i_reset) begin
         o_cu_flush = 3'b111;
      end else begin
         unique case (r_state)
            StRun: begin
               if (w_timeout) begin
                  w_exc_take  = 1'b1;
                  w_stall_nxt = '0;
               end else if (i_mem_stall) begin
                  o_cu_stall = 5'b11111;
               end else if (i_mem_excepttype == CodeEret) begin
                  o_cu_pc_src = PcEret;
                  o_cu_flush  = 3'b111;
               end else if (i_mem_excepttype != '0) begin
                  w_exc_take = 1'b1;
               end else if (i_mem_branch_state || i_mem_jr) begin
                  o_cu_pc_src = PcCtrl;
                  o_cu_flush  = 3'b011;
               end else if (i_id_jmp) begin
                  o_cu_pc_src = PcJmp;
               end else if (w_load_use) begin
                  o_cu_stall = 5'b00011;
                  o_cu_flush = 3'b010;
               end

               if (w_exc_take) begin
                  o_cu_pc_src = PcExcept;
                  o_cu_flush  = 3'b111;
                  o_cu_vector = w_exc_vec;
                  w_cause_nxt = w_code[4:0];
                  w_drain_nxt = DrainInit;
                  w_state_nxt = (DRAIN_CYCLES > 1) ? StDrain : StRun;
               end
            end
            StDrain: begin
               o_cu_flush    = 3'b111;
               o_cu_exc_busy = 1'b1;
               // Entry cycle already flushed once, so leave as the count reaches zero.
               if (i_mem_stall) begin
                  o_cu_stall = 5'b11111;
               end else begin
                  w_drain_nxt = r_drain_cnt - 1'b1;
                  if (r_drain_cnt <= DrainW'(1)) begin
                     w_drain_nxt = '0;
                     w_state_nxt = StRun;
                  end
               end
            end
            default: w_state_nxt = StRun;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= StRun;
         r_drain_cnt <= '0;
         r_stall_cnt <= '0;
         r_cause     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_nxt;
         r_stall_cnt <= w_stall_nxt;
         r_cause     <= w_cause_nxt;
      end
   end

endmodule
